// File: rtl/param_datapath_if.sv
// Bus bundle for param_datapath: slice/write/read controls in, ALU result and flag out.
// Widths follow the same parameters as the datapath instance it connects to.
interface param_datapath_if #(
    parameter int IN_WIDTH     = 64,
    parameter int DATA_WIDTH   = 7,
    parameter int SLICE_STRIDE = 8,
    parameter int NREGS        = 16
);
    localparam int SEL_W = $clog2(IN_WIDTH / SLICE_STRIDE);
    localparam int AW    = $clog2(NREGS);

    logic [IN_WIDTH-1:0]   InPort;
    logic [SEL_W-1:0]      Sel;
    logic                  Wen;
    logic                  WSRC;
    logic [AW-1:0]         WA;
    logic [AW-1:0]         RAA;
    logic [AW-1:0]         RAB;
    logic [2:0]            Op;
    logic [DATA_WIDTH-1:0] OutPort;
    logic                  Flag;

    modport master (
        output InPort, Sel, Wen, WSRC, WA, RAA, RAB, Op,
        input  OutPort, Flag
    );

    modport slave (
        input  InPort, Sel, Wen, WSRC, WA, RAA, RAB, Op,
        output OutPort, Flag
    );
endinterface

// File: rtl/param_datapath.sv
// Slice loader + register file + 2-operand ALU; OutPort/Flag latency 0 (OUT_REG=0) or 1 (OUT_REG=1).
// No backpressure: one write and one ALU result every cycle.
module param_datapath #(
    parameter int IN_WIDTH     = 64,
    parameter int DATA_WIDTH   = 7,
    parameter int SLICE_STRIDE = 8,
    parameter int NREGS        = 16,
    parameter bit OUT_REG      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    param_datapath_if.slave bus
);
    typedef logic [DATA_WIDTH-1:0] data_t;

    data_t                       regs [NREGS];
    data_t                       slice;
    data_t                       op_a;
    data_t                       op_b;
    data_t                       alu_res;
    data_t                       wdata;
    logic                        alu_flag;
    logic [DATA_WIDTH:0]         alu_wide;
    logic [IN_WIDTH+DATA_WIDTH-1:0] in_ext;

    // Zero padding above the bus makes slices that run past the top read as 0.
    assign in_ext = {{DATA_WIDTH{1'b0}}, bus.InPort};
    assign slice  = data_t'(in_ext >> (bus.Sel * SLICE_STRIDE));

    assign op_a  = regs[bus.RAA];
    assign op_b  = regs[bus.RAB];
    assign wdata = bus.WSRC ? alu_res : slice;

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        alu_wide = '0;
        unique case (bus.Op)
            3'd0: begin
                alu_wide = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = alu_wide[DATA_WIDTH-1:0];
                alu_flag = alu_wide[DATA_WIDTH];
            end
            3'd1: begin
                alu_res  = op_a >> 1;
                alu_flag = op_a[0];
            end
            3'd2: begin
                // Extra MSB of the widened difference is the borrow (A < B).
                alu_wide = {1'b0, op_a} - {1'b0, op_b};
                alu_res  = alu_wide[DATA_WIDTH-1:0];
                alu_flag = alu_wide[DATA_WIDTH];
            end
            3'd3: alu_res = op_a & op_b;
            3'd4: alu_res = op_a;
            3'd5: alu_res = op_a | op_b;
            3'd6: alu_res = op_a ^ op_b;
            3'd7: alu_res = ~op_a;
        endcase
        if (bus.Op >= 3'd3) begin
            alu_flag = (alu_res == '0);
        end
    end

    // Reads see the pre-write contents; there is no write-to-read bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.Wen) begin
            regs[bus.WA] <= wdata;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            data_t out_q;
            logic  flag_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q  <= '0;
                    flag_q <= 1'b0;
                end else begin
                    out_q  <= alu_res;
                    flag_q <= alu_flag;
                end
            end

            assign bus.OutPort = out_q;
            assign bus.Flag    = flag_q;
        end else begin : g_out_comb
            assign bus.OutPort = alu_res;
            assign bus.Flag    = alu_flag;
        end
    endgenerate
endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: default, 60-bit-input and registered-output instances.
module tb_param_datapath;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    param_datapath_if                  b0 ();
    param_datapath_if #(.IN_WIDTH(60)) b60 ();
    param_datapath_if                  b1 ();

    param_datapath                                   u0  (.clk(clk), .rst(rst), .bus(b0));
    param_datapath #(.IN_WIDTH(60))                  u60 (.clk(clk), .rst(rst), .bus(b60));
    param_datapath #(.OUT_REG(1'b1))                 u1  (.clk(clk), .rst(rst), .bus(b1));

    typedef struct packed {
        logic [6:0] out;
        logic       flag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] o, input logic f);
        exp_t e;
        e.out  = o;
        e.flag = f;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input logic [6:0] o, input logic f);
        exp_t e;
        chk({tag, "_pending"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_out"}, 32'(o), 32'(e.out));
            chk({tag, "_flag"}, 32'(f), 32'(e.flag));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Combinational instance: sample 1ns after the inputs settle, well before the next edge.
    task automatic check0(input string tag);
        #1;
        pop_cmp(tag, b0.OutPort, b0.Flag);
    endtask

    task automatic load0(input logic [3:0] wa, input logic [2:0] sel, input logic [63:0] din);
        b0.Wen    = 1'b1;
        b0.WSRC   = 1'b0;
        b0.WA     = wa;
        b0.Sel    = sel;
        b0.InPort = din;
        cyc();
        b0.Wen    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {b0.InPort, b0.Sel, b0.Wen, b0.WSRC, b0.WA, b0.RAA, b0.RAB, b0.Op} = '0;
        {b60.InPort, b60.Sel, b60.Wen, b60.WSRC, b60.WA, b60.RAA, b60.RAB, b60.Op} = '0;
        {b1.InPort, b1.Sel, b1.Wen, b1.WSRC, b1.WA, b1.RAA, b1.RAB, b1.Op} = '0;
        rst = 1'b0;
        #1;
        rst = 1'b1;

        // Reset with arbitrary inputs, including a pending write
        b0.InPort = {$urandom, $urandom};
        b0.Wen = 1'b1; b0.WA = 4'd3; b0.RAA = 4'd3; b0.Op = 3'd4;
        b1.InPort = {$urandom, $urandom};
        b1.Wen = 1'b1; b1.WA = 4'd0; b1.RAA = 4'd0; b1.Op = 3'd4;
        #12;
        push_exp(7'h00, 1'b0);
        pop_cmp("rst_oreg", b1.OutPort, b1.Flag);
        push_exp(7'h00, 1'b1);
        check0("rst_comb");
        b0.Wen = 1'b0;
        b1.Wen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc();

        b0.RAA = 4'd9; b0.Op = 3'd4;
        push_exp(7'h00, 1'b1);
        check0("post_rst_mov");

        // Load byte 2 of the bus, then MOV and SHR
        load0(4'd5, 3'd2, 64'h0123_4567_89AB_CDEF);
        b0.RAA = 4'd5; b0.Op = 3'd4;
        push_exp(7'h2B, 1'b0);
        check0("load_mov");
        b0.Op = 3'd1;
        push_exp(7'h15, 1'b1);
        check0("shr");

        // Arithmetic and logic flags on 0x7F / 0x01
        load0(4'd1, 3'd0, 64'h7F);
        load0(4'd2, 3'd0, 64'h01);
        b0.RAA = 4'd1; b0.RAB = 4'd2; b0.Op = 3'd0;
        push_exp(7'h00, 1'b1);
        check0("add_carry");
        b0.RAA = 4'd2; b0.RAB = 4'd1; b0.Op = 3'd2;
        push_exp(7'h02, 1'b1);
        check0("sub_borrow");
        b0.RAA = 4'd1; b0.RAB = 4'd2; b0.Op = 3'd2;
        push_exp(7'h7E, 1'b0);
        check0("sub_noborrow");
        b0.Op = 3'd3;
        push_exp(7'h01, 1'b0);
        check0("and");
        b0.Op = 3'd5;
        push_exp(7'h7F, 1'b0);
        check0("or");
        b0.Op = 3'd7;
        push_exp(7'h00, 1'b1);
        check0("not_zero");
        b0.RAA = 4'd2; b0.RAB = 4'd2; b0.Op = 3'd6;
        push_exp(7'h00, 1'b1);
        check0("xor_same_reg");

        // ALU write-back into reg3
        b0.Wen = 1'b1; b0.WSRC = 1'b1; b0.WA = 4'd3;
        b0.RAA = 4'd1; b0.RAB = 4'd2; b0.Op = 3'd6;
        push_exp(7'h7E, 1'b0);
        check0("wb_xor");
        cyc();
        b0.Wen = 1'b0; b0.WSRC = 1'b0;
        b0.RAA = 4'd3; b0.Op = 3'd4;
        push_exp(7'h7E, 1'b0);
        check0("wb_readback");

        // Same-cycle write/read of reg5 returns the old value
        b0.Wen = 1'b1; b0.WA = 4'd5; b0.Sel = 3'd7;
        b0.InPort = 64'hFF00_0000_0000_0000;
        b0.RAA = 4'd5; b0.Op = 3'd4;
        push_exp(7'h2B, 1'b0);
        check0("hazard_old");
        cyc();
        b0.Wen = 1'b0;
        push_exp(7'h7F, 1'b0);
        check0("hazard_new");

        // Wen=0 leaves the register untouched
        b0.WA = 4'd5; b0.Sel = 3'd0; b0.InPort = 64'h0;
        cyc();
        push_exp(7'h7F, 1'b0);
        check0("no_wen");

        // 60-bit bus: slice 7 reaches past the top, bits 60..62 read as 0
        b60.Wen = 1'b1; b60.WSRC = 1'b0; b60.WA = 4'd0; b60.Sel = 3'd7;
        b60.InPort = '1;
        cyc();
        b60.Wen = 1'b0;
        b60.RAA = 4'd0; b60.Op = 3'd4;
        #1;
        push_exp(7'h0F, 1'b0);
        pop_cmp("oob_slice", b60.OutPort, b60.Flag);

        // Registered output: result of cycle t appears at t+1
        b1.Wen = 1'b1; b1.WSRC = 1'b0; b1.WA = 4'd5; b1.Sel = 3'd2;
        b1.InPort = 64'h0123_4567_89AB_CDEF;
        b1.RAA = 4'd0; b1.Op = 3'd4;
        cyc();
        b1.Wen = 1'b0;
        b1.RAA = 4'd5; b1.Op = 3'd4;
        push_exp(7'h2B, 1'b0);
        #1;
        chk("oreg_not_yet", 32'(b1.OutPort), 32'h00);
        cyc();
        pop_cmp("oreg_mov", b1.OutPort, b1.Flag);
        b1.Op = 3'd7;
        push_exp(7'h54, 1'b0);
        cyc();
        pop_cmp("oreg_not", b1.OutPort, b1.Flag);

        // Mid-cycle reset clears the output register and the register files at once
        #2;
        rst = 1'b1;
        #1;
        push_exp(7'h00, 1'b0);
        pop_cmp("rst_mid_oreg", b1.OutPort, b1.Flag);
        b0.RAA = 4'd5; b0.Op = 3'd4;
        push_exp(7'h00, 1'b1);
        check0("rst_mid_regs");
        @(negedge clk);
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
Parametrised successor of the fixed 64-bit/7-bit slice datapath.
- Loads a slice of a wide input bus into a register file.
- Runs a 2-operand ALU over two read ports and drives OutPort/Flag.
- New in this generation: configurable widths and depth, an optional registered output stage, and ALU write-back into the register file.
- Sits between the input bus and the downstream 7-segment/output logic. The formal assertion bench targets it.

Parameters:
IN_WIDTH, 64, width of InPort.
DATA_WIDTH, 7, register, ALU and OutPort width.
SLICE_STRIDE, 8, bit stride between selectable slices; slice k starts at bit k*SLICE_STRIDE.
NREGS, 16, register-file depth (power of 2, >=2).
OUT_REG, 0, 0 = OutPort/Flag combinational from read ports; 1 = registered, one extra cycle.
Derived: SEL_W = $clog2(IN_WIDTH/SLICE_STRIDE); AW = $clog2(NREGS).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
InPort  in  IN_WIDTH  wide input bus
Sel  in  SEL_W  slice selector
Wen  in  1  register-file write enable
WSRC  in  1  write source: 0 = InPort slice, 1 = ALU result
WA  in  AW  write address
RAA  in  AW  read address A (ALU operand A)
RAB  in  AW  read address B (ALU operand B)
Op  in  3  ALU opcode
OutPort  out  DATA_WIDTH  ALU result
Flag  out  1  ALU status flag

Behaviour:
Reset:
- rst high clears all NREGS registers to 0 immediately, independent of clk.
- In OUT_REG=1, the output register is also cleared: OutPort=0, Flag=0.
- In OUT_REG=0, OutPort/Flag follow the ALU on the cleared registers: MOV of reg 0 gives OutPort=0.
- Deassertion takes effect at the next rising edge.

Slice extraction:
- slice[i] = InPort[Sel*SLICE_STRIDE + i] for i in 0..DATA_WIDTH-1.
- Any bit index >= IN_WIDTH reads as 0; there is no wrap-around.

Write:
- On a rising edge with Wen=1: reg[WA] <= (WSRC ? alu_result : slice).
- Wen=0: no register changes. There is one write per cycle.

Read:
- A = reg[RAA], B = reg[RAB], combinational.
- No write-to-read bypass: a read of WA in the cycle it is written returns the old value; the new value is visible from the next cycle.
- RAA==RAB is legal.

ALU (all results truncated to DATA_WIDTH):
- 0 ADD: A+B; Flag = carry out.
- 1 SHR: A>>1, MSB=0; Flag = A[0].
- 2 SUB: A-B mod 2^DATA_WIDTH; Flag = borrow (A<B).
- 3 AND: A&B; Flag = (result==0).
- 4 MOV: A; Flag = (result==0).
- 5 OR: A|B; Flag = (result==0).
- 6 XOR: A^B; Flag = (result==0).
- 7 NOT: ~A; Flag = (result==0).

Output timing:
- OUT_REG=0: OutPort/Flag are valid in the same cycle as RAA/RAB/Op (latency 0).
- OUT_REG=1: OutPort/Flag are registered and show the result of cycle t's inputs during cycle t+1.
- Write-back (WSRC=1) always uses the combinational alu_result of the current cycle, in both modes.

Reset mid-operation:
- Any in-flight write is lost.
- The registered output is cleared asynchronously.

Write with rst high: ignored.

Test Plan:
1. Reset: assert rst with arbitrary inputs -> OutPort=0, Flag=0 (OUT_REG=1) and, after release, Op=4 with any RAA -> OutPort=0x00, Flag=1.
2. Load + MOV/SHR:
   - Stimulus: InPort=64'h0123_4567_89AB_CDEF, Sel=2, WA=5, Wen=1, WSRC=0.
   - Next cycle, RAA=5, Op=4 -> OutPort=0x2B, Flag=0.
   - Then Op=1 -> OutPort=0x15, Flag=1.
3. Arithmetic flags:
   - Setup: load reg1=0x7F (Sel=0, byte0=0x7F) and reg2=0x01.
   - RAA=1, RAB=2, Op=0 -> OutPort=0x00, Flag=1.
   - RAA=2, RAB=1, Op=2 -> OutPort=0x02, Flag=1.
   - RAA=1, RAB=2, Op=2 -> 0x7E, Flag=0.
4. Write-back: Wen=1, WSRC=1, WA=3, RAA=1, RAB=2, Op=6 -> next cycle RAA=3, Op=4 gives OutPort=0x7E.
5. Same-cycle hazard and out-of-range slice:
   - Setup: reg5=0x2B.
   - Same cycle: Wen=1, WA=5, Sel=7, InPort[63:56]=0xFF, RAA=5, Op=4 -> OutPort=0x2B that cycle, 0x7F next.
   - With IN_WIDTH=60 instance, Sel=7 -> upper bits 60..62 read as 0 -> 0x0F.
6. OUT_REG=1 instance:
   - Op=4 on reg5=0x2B at cycle t -> OutPort=0x2B at t+1, not at t.
   - Assert rst mid-cycle -> OutPort=0 immediately, before the next edge.
